dmem_refill_ctrl: RTL
=====================

# dmem_refill_ctrl

Miss-handling and write-through controller between the direct-mapped data cache and data memory in the memory stage of the pipelined RISC-V core. On a load miss it stalls the pipeline, fetches the word from data memory over a req/ack handshake and presents it to the cache as a one-cycle fill. Stores are written through via a small FIFO write buffer, which is always drained before a miss read so loads never bypass older stores.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- WB_DEPTH, 2, write-buffer entries (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load_i  in  1  memory-stage instruction is a load
- store_i  in  1  memory-stage instruction is a store
- miss_i  in  1  cache reports miss for the current load
- addr_i  in  ADDR_WIDTH  byte address from ALU
- wdata_i  in  DATA_WIDTH  store data
- stall_o  out  1  freeze pipeline (combinational)
- fill_valid_o  out  1  one-cycle pulse: write fill into cache
- fill_addr_o  out  ADDR_WIDTH  word-aligned fill address
- fill_data_o  out  DATA_WIDTH  fill word
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_WIDTH  word-aligned memory address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_rdata_i  in  DATA_WIDTH  read data, valid with ack on reads
- mem_ack_i  in  1  request complete; sampled only while mem_req_o=1

## Operation
- States: IDLE, DRAIN, READ, FILL. Write buffer: circular FIFO of {addr[ADDR_WIDTH-1:2],data}, head/tail pointers wrap modulo WB_DEPTH, count 0..WB_DEPTH.
- IDLE: if buffer non-empty, mem_req_o=1, mem_we_o=1, addr/data = head entry; on ack pop head.
- IDLE, load_i & miss_i: latch {addr_i[ADDR_WIDTH-1:2],2'b00}; next state DRAIN if buffer non-empty (after any same-cycle pop), else READ.
- DRAIN: keeps issuing head writes; go to READ the cycle after the pop that empties the buffer.
- READ: mem_req_o=1, mem_we_o=0, mem_addr_o = latched address; on ack capture mem_rdata_i, go FILL.
- FILL: fill_valid_o=1, fill_addr_o/fill_data_o = latched values; go IDLE unconditionally.
- Store in IDLE: enqueued at edge if count<WB_DEPTH, or count==WB_DEPTH and a pop occurs the same cycle; otherwise stalled and retried each cycle (pipeline holds inputs).
- Simultaneous push and pop: count unchanged, both pointers advance.
- load_i & store_i together: illegal; treated as store, load ignored.
- Load hit (miss_i=0) and non-memory instructions: no action, no stall.
- Memory address bits [1:0] always 0.

## Timing
- stall_o = (state≠IDLE) | (load_i & miss_i & state==IDLE) | (store_i & buffer full & no pop this cycle).
- stall_o deasserts the cycle after FILL; cache hits on the replayed load then.
- Miss, empty buffer, ack on first READ cycle: T0 IDLE detect, T1 READ+ack, T2 FILL, T3 IDLE, stall_o high T0–T2 (3 cycles). Each extra ack wait cycle adds one.
- Each buffered write ahead of a miss adds ≥1 cycle (one per ack).
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o stable from first assertion until ack cycle inclusive.
- Reset values: state IDLE, buffer empty, stall_o follows formula with empty buffer, fill_valid_o=0, fill_addr_o=0, fill_data_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- rst mid-transaction: at the next edge all state cleared, buffered stores discarded, mem_req_o low the following cycle; a late ack is ignored since mem_req_o=0.

## Test plan
- Load miss addr 0x0000_0104, empty buffer, ack same cycle as req, rdata 0xDEADBEEF -> stall_o high exactly 3 cycles, fill_valid_o one pulse with fill_addr_o=0x104, fill_data_o=0xDEADBEEF, mem_we_o=0.
- Two stores (0x10←0x11, 0x14←0x22) with memory ack held low, then third store -> first two no stall, third stalls until first ack; writes reach memory in order 0x10, 0x14, 0x18.
- Store 0x20←0xAA then immediate load miss at 0x20, ack 2 cycles after each req -> write to 0x20 completes before read req; no read issued while mem_we_o=1 pending.
- Load miss addr 0x0000_0107 -> mem_addr_o=0x104, fill_addr_o=0x104.
- Full buffer, store with same-cycle pop -> store accepted, no stall, count stays WB_DEPTH.
- rst asserted in READ with ack withheld, ack pulsed after reset -> outputs at reset values, no fill_valid_o, buffer empty.

Source files
------------

// File: rtl/dmem_refill_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the data-cache refill controller.
// master = controller, slave = surrounding pipeline/cache/memory.
interface dmem_refill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  load_i;
  logic                  store_i;
  logic                  miss_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  stall_o;
  logic                  fill_valid_o;
  logic [ADDR_WIDTH-1:0] fill_addr_o;
  logic [DATA_WIDTH-1:0] fill_data_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport master (
    input  load_i, store_i, miss_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    output stall_o, fill_valid_o, fill_addr_o, fill_data_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output load_i, store_i, miss_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    input  stall_o, fill_valid_o, fill_addr_o, fill_data_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_refill_ctrl.sv
// Load-miss refill and store write-through controller; stores sit in a small FIFO
// that is always drained to memory before a miss read is issued.
module dmem_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WB_DEPTH   = 2
) (
  input logic               clk,
  input logic               rst,
  dmem_refill_ctrl_if.master bus
);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(WB_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_READ, ST_FILL} state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wb_addr_q [WB_DEPTH];
  logic [WW-1:0]         wb_addr_d [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_d [WB_DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PW:0]           count_q, count_d, count_after_pop;
  logic [WW-1:0]         miss_addr_q, miss_addr_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;

  logic wb_empty, wb_full, wr_pend, pop, push, load_miss, store_blk;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr_i[1:0];

  assign wb_empty  = (count_q == '0);
  assign wb_full   = (count_q == FULL_CNT);
  // Writes drain from the head whenever no miss read owns the memory port.
  assign wr_pend   = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && !wb_empty;
  assign pop       = wr_pend && bus.mem_ack_i;
  assign load_miss = (state_q == ST_IDLE) && bus.load_i && bus.miss_i && !bus.store_i;
  assign push      = (state_q == ST_IDLE) && bus.store_i && (!wb_full || pop);
  assign store_blk = (state_q == ST_IDLE) && bus.store_i && wb_full && !pop;
  assign count_after_pop = pop ? (count_q - CNT_ONE) : count_q;

  assign bus.stall_o      = (state_q != ST_IDLE) || load_miss || store_blk;
  assign bus.fill_valid_o = (state_q == ST_FILL);
  assign bus.fill_addr_o  = (state_q == ST_FILL) ? {miss_addr_q, 2'b00} : '0;
  assign bus.fill_data_o  = (state_q == ST_FILL) ? fill_data_q : '0;
  assign bus.mem_req_o    = wr_pend || (state_q == ST_READ);
  assign bus.mem_we_o     = wr_pend;
  assign bus.mem_addr_o   = wr_pend ? {wb_addr_q[head_q], 2'b00} :
                            (state_q == ST_READ) ? {miss_addr_q, 2'b00} : '0;
  assign bus.mem_wdata_o  = wr_pend ? wb_data_q[head_q] : '0;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    miss_addr_d = miss_addr_q;
    fill_data_d = fill_data_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;

    if (push) begin
      wb_addr_d[tail_q] = bus.addr_i[ADDR_WIDTH-1:2];
      wb_data_d[tail_q] = bus.wdata_i;
      tail_d            = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (load_miss) begin
          miss_addr_d = bus.addr_i[ADDR_WIDTH-1:2];
          state_d     = (count_after_pop != '0) ? ST_DRAIN : ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop && (count_q == CNT_ONE)) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (bus.mem_ack_i) begin
          fill_data_d = bus.mem_rdata_i;
          state_d     = ST_FILL;
        end
      end
      ST_FILL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      miss_addr_q <= '0;
      fill_data_q <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end
endmodule
